// File: rtl/ahb_sram_slv.sv
// AHB slave SRAM: word array with byte/halfword/word lanes, WAIT_STATES wait cycles, two-cycle ERROR.
// Latency: address phase + WAIT_STATES hready-low cycles + one DONE cycle; errors take ERR1 + ERR2.
// Backpressure: hready low in WAIT/ERR1 stalls the master; AHB_SLV_WRPROT_EN adds wr_prot_i write protection.
module ahb_sram_slv #(
   parameter int AWIDTH      = 32,
   parameter int DWIDTH      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hsel,
   input  logic [AWIDTH-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [DWIDTH-1:0] hwdata,
`ifdef AHB_SLV_WRPROT_EN
   input  logic              wr_prot_i,
`endif
   output logic [DWIDTH-1:0] hrdata,
   output logic              hready,
   output logic [1:0]        hresp
);

   localparam int                IW    = $clog2(MEM_DEPTH);
   localparam logic [AWIDTH-1:0] LIMIT = AWIDTH'(MEM_DEPTH * 4);
   localparam logic [3:0]        WS    = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IW+1:0]     addr_q;
   logic              wr_q;
   logic [1:0]        size_q;
   logic [DWIDTH-1:0] hrdata_q;
   logic [DWIDTH-1:0] mem [MEM_DEPTH];

   logic              req;
   logic              accept;
   logic              acc_err;
   logic              prot_err;
   logic [IW-1:0]     idx;
   logic [3:0]        be;
   logic              mem_we;
   logic              rd_done;
   logic              unused_burst;

   // Bursts are handled beat by beat, so the burst type carries no information here.
   assign unused_burst = ^hburst;

`ifdef AHB_SLV_WRPROT_EN
   assign prot_err = hwrite & wr_prot_i;
`else
   assign prot_err = 1'b0;
`endif

   assign hready  = (state_q != S_WAIT) && (state_q != S_ERR1);
   assign hresp   = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
   assign req     = hsel & htrans[1];
   assign accept  = req & hready;
   assign acc_err = (hsize > 3'b010) || (haddr >= LIMIT) ||
                    ((hsize == 3'b001) && haddr[0]) ||
                    ((hsize == 3'b010) && (haddr[1:0] != 2'b00)) || prot_err;

   assign idx     = addr_q[IW+1:2];
   assign mem_we  = (state_q == S_DONE) && wr_q;
   assign rd_done = (state_q == S_DONE) && !wr_q;

   // Read data comes straight from the array in DONE so a write committed on the previous edge is visible.
   assign hrdata  = rd_done ? mem[idx] : hrdata_q;

   // Next state and wait counter; IDLE, DONE and ERR2 all act as accept points.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR2: begin
            if (req) begin
               if (acc_err) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'd1;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == WS) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   // Byte enables from the latched size and low address bits (little-endian lanes).
   always_comb begin
      be = 4'b0000;
      case (size_q)
         2'b00:   be[addr_q[1:0]] = 1'b1;
         2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Control state, address-phase capture and held read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         size_q   <= 2'b00;
         hrdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= haddr[IW+1:0];
            wr_q   <= hwrite;
            size_q <= hsize[1:0];
         end
         if (rd_done) begin
            hrdata_q <= mem[idx];
         end
      end
   end

   // Write lanes commit on the edge that ends DONE; the array itself is never reset.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

endmodule
